lfsr_bank_seq: RTL

- Parametrised, multi-channel successor to the single 8-bit XNOR LFSR used for pseudo-random hidden-layer weight generation in the ELM datapath.
- Holds NUM_CH independent Fibonacci XNOR LFSRs of WIDTH bits each, with a configurable tap mask and loadable seeds.
- A burst sequencer emits LEN random weight vectors per request over a valid/ready handshake, and flags and recovers from XNOR lock-up.
- Sits between the control FSM and the hidden-neuron MAC array.

---
 rtl/lfsr_bank_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lfsr_bank_seq.sv
// Bank of NUM_CH Fibonacci XNOR LFSRs with a burst sequencer that streams
// LEN pseudo-random weight vectors over valid/ready and recovers from lock-up.
module lfsr_bank_seq #(
    parameter int                 WIDTH  = 8,
    parameter int                 NUM_CH = 4,
    parameter logic [WIDTH-1:0]   TAPS   = WIDTH'(8'b0001_1101),
    parameter int                 LEN_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      load_seed,
    input  logic [WIDTH-1:0]          seed_in,
    input  logic                      step_en,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len_in,
    input  logic                      out_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done,
    output logic [LEN_W-1:0]          word_cnt,
    output logic                      lockup_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        fsm_q, fsm_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  ch_q, ch_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  step_val;
    logic [NUM_CH-1:0]             lock_vec;
    logic [LEN_W-1:0]              len_q, len_d;
    logic [LEN_W-1:0]              word_cnt_q, word_cnt_d;
    logic                          lockup_q, lockup_d;
    logic                          do_step;
    logic                          last_xfer;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            lockup_q   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_q[c] <= WIDTH'(c);
            end
        end else begin
            fsm_q      <= fsm_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            lockup_q   <= lockup_d;
            ch_q       <= ch_d;
        end
    end

    // All-ones is the XNOR fixed point, so it is forced to zero instead of stepping.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lock_vec[c] = &ch_q[c];
            step_val[c] = lock_vec[c] ? '0 : {~^(ch_q[c] & TAPS), ch_q[c][WIDTH-1:1]};
        end
    end

    assign last_xfer = ((word_cnt_q + LEN_W'(1)) == len_q);

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        if (clr) begin
            fsm_d = S_IDLE;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (start && !load_seed) begin
                        fsm_d = (len_in != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (out_ready && last_xfer) begin
                        fsm_d = S_DONE;
                    end
                end
                S_DONE:  fsm_d = S_IDLE;
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values
    always_comb begin
        ch_d       = ch_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        lockup_d   = lockup_q;
        do_step    = 1'b0;
        if (clr) begin
            len_d      = '0;
            word_cnt_d = '0;
            lockup_d   = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_d[c] = WIDTH'(c);
            end
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (load_seed) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            ch_d[c] = seed_in ^ WIDTH'(c);
                        end
                    end else if (start) begin
                        len_d      = len_in;
                        word_cnt_d = '0;
                    end else if (step_en) begin
                        do_step = 1'b1;
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        do_step    = 1'b1;
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
            if (do_step) begin
                ch_d = step_val;
                if (|lock_vec) begin
                    lockup_d = 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        out_valid = (fsm_q == S_RUN);
        busy      = (fsm_q != S_IDLE);
        done      = (fsm_q == S_DONE);
    end

    assign out_data   = ch_q;
    assign word_cnt   = word_cnt_q;
    assign lockup_err = lockup_q;

endmodule
